// File: rtl/universal_shiftreg.sv
// Universal shift register with a start/done handshake: load, hold, SHL, SHR,
// ROL, ROR and ASR, multi-position shifts executed one position per clock.
module universal_shiftreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             pre,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  // Next-state and data path
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mode)
            M_LOAD: begin
              q_d    = din;
              done_d = 1'b1;
            end
            M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: begin
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                mode_d  = mode;
                cnt_d   = amt;
                busy_d  = 1'b1;
                state_d = ST_SHIFT;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_SHIFT: begin
        case (mode_q)
          M_SHL: begin
            q_d    = {q_q[WIDTH-2:0], sin};
            sout_d = q_q[WIDTH-1];
          end
          M_SHR: begin
            q_d    = {sin, q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          M_ROL: begin
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
          end
          M_ROR: begin
            q_d    = {q_q[0], q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          M_ASR: begin
            q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          default: q_d = q_q;
        endcase
        cnt_d = AMT_W'(cnt_q - AMT_W'(1));
        if (cnt_q == AMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset beats preset beats normal operation; both abort a running shift
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
    end else if (pre) begin
      state_q <= ST_IDLE;
      q_q     <= '1;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_universal_shiftreg.sv
// Self-checking bench for universal_shiftreg: directed scenarios plus random
// commands checked against an arithmetic reference model.
module tb_universal_shiftreg;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          res, pre, start, sin;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  din;
  logic [W-1:0]  q;
  logic          sout, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_q;
  logic         m_sout;

  universal_shiftreg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .res(res), .pre(pre), .start(start), .mode(mode), .amt(amt),
    .din(din), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-command result from the operation's arithmetic definition; sin held constant
  function automatic logic [W:0] ref_cmd(input logic [2:0] md, input int n,
                                         input logic [W-1:0] qv, input logic so,
                                         input logic s, input logic [W-1:0] d);
    int qi, m, k, r, fill, nq, ns, sg;
    qi = int'(qv); m = (1 << W) - 1; k = (n < W) ? n : W; r = n % W;
    nq = qi; ns = int'(so);
    case (md)
      3'd1: nq = int'(d);
      3'd2: if (n > 0) begin
        fill = s ? ((1 << k) - 1) : 0;
        nq = ((qi << k) | fill) & m;
        ns = (n <= W) ? ((qi >> (W - n)) & 1) : int'(s);
      end
      3'd3: if (n > 0) begin
        fill = s ? (m & ~(m >> k)) : 0;
        nq = (qi >> k) | fill;
        ns = (n <= W) ? ((qi >> (n - 1)) & 1) : int'(s);
      end
      3'd4: if (n > 0) begin
        nq = ((qi << r) | (qi >> (W - r))) & m;
        ns = nq & 1;
      end
      3'd5: if (n > 0) begin
        nq = ((qi >> r) | (qi << (W - r))) & m;
        ns = (nq >> (W - 1)) & 1;
      end
      3'd6: if (n > 0) begin
        sg = (qi >> (W - 1)) & 1;
        fill = (sg != 0) ? (m & ~(m >> k)) : 0;
        nq = (qi >> k) | fill;
        ns = (n <= W) ? ((qi >> (n - 1)) & 1) : sg;
      end
      default: ;
    endcase
    return {1'(ns), W'(nq)};
  endfunction

  function automatic int exp_busy(input logic [2:0] md, input int n);
    return (md >= 3'd2 && md <= 3'd6) ? n : 0;
  endfunction

  // Issue one command and follow it to completion; called just after an edge
  task automatic do_cmd(input string tag, input logic [2:0] md, input logic [AW-1:0] n,
                        input logic [W-1:0] d, input logic s);
    int bc, guard;
    logic [W:0] e;
    e = ref_cmd(md, int'(n), m_q, m_sout, s, d);
    start = 1'b1; mode = md; amt = n; din = d; sin = s;
    tick();
    start = 1'b0;
    bc = 0; guard = 0;
    while (busy && guard < 64) begin
      check({tag, "_done_early"}, 32'(done), 32'd0);
      bc++;
      tick();
      guard++;
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy(md, int'(n))));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_q"}, 32'(q), 32'(e[W-1:0]));
    check({tag, "_sout"}, 32'(sout), 32'(e[W]));
    m_q = e[W-1:0]; m_sout = e[W];
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W:0] e;
    bit seen_done;
    int guard;
    res = 1'b1; pre = 1'b0; start = 1'b0; mode = '0; amt = '0; din = '0; sin = 1'b0;
    tick(); tick();
    res = 1'b0;
    check("rst_q", 32'(q), 32'h00);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    pre = 1'b1; tick(); pre = 1'b0;
    check("pre_q", 32'(q), 32'hFF);
    res = 1'b1; pre = 1'b1; tick(); res = 1'b0; pre = 1'b0;
    check("res_pre_q", 32'(q), 32'h00);
    m_q = '0; m_sout = 1'b0;

    do_cmd("load", 3'd1, 3'd0, 8'hA5, 1'b0);
    check("load_val", 32'(q), 32'hA5);

    // SHL by 3 with visible intermediate values
    start = 1'b1; mode = 3'd2; amt = 3'd3; sin = 1'b1;
    tick(); start = 1'b0;
    check("shl3_busy_e0", 32'(busy), 32'd1);
    tick(); check("shl3_e1", 32'(q), 32'h4B); check("shl3_busy_e1", 32'(busy), 32'd1);
    tick(); check("shl3_e2", 32'(q), 32'h97); check("shl3_busy_e2", 32'(busy), 32'd1);
    tick(); check("shl3_e3", 32'(q), 32'h2F);
    check("shl3_done", 32'(done), 32'd1); check("shl3_busy_e3", 32'(busy), 32'd0);
    check("shl3_sout", 32'(sout), 32'd1);
    tick(); check("shl3_done_pulse", 32'(done), 32'd0);
    m_q = 8'h2F; m_sout = 1'b1;

    do_cmd("ld3c", 3'd1, 3'd0, 8'h3C, 1'b0);
    do_cmd("ror4", 3'd5, 3'd4, 8'h00, 1'b0); check("ror4_val", 32'(q), 32'hC3);
    do_cmd("ld81", 3'd1, 3'd0, 8'h81, 1'b0);
    do_cmd("rol7", 3'd4, 3'd7, 8'h00, 1'b0); check("rol7_val", 32'(q), 32'hC0);
    do_cmd("ld90", 3'd1, 3'd0, 8'h90, 1'b0);
    do_cmd("asr2", 3'd6, 3'd2, 8'h00, 1'b1); check("asr2_val", 32'(q), 32'hE4);
    check("asr2_sout", 32'(sout), 32'd0);
    do_cmd("ldff", 3'd1, 3'd0, 8'hFF, 1'b0);
    do_cmd("shr7", 3'd3, 3'd7, 8'h00, 1'b0); check("shr7_val", 32'(q), 32'h01);

    // start while busy is ignored
    do_cmd("ld5a", 3'd1, 3'd0, 8'h5A, 1'b0);
    e = ref_cmd(3'd2, 5, 8'h5A, m_sout, 1'b0, 8'h00);
    start = 1'b1; mode = 3'd2; amt = 3'd5; sin = 1'b0;
    tick(); start = 1'b0;
    tick(); start = 1'b1; mode = 3'd1; din = 8'h00;
    tick(); start = 1'b0;
    check("intf_busy", 32'(busy), 32'd1);
    guard = 0;
    while (!done && guard < 20) begin tick(); guard++; end
    check("intf_done", 32'(done), 32'd1);
    check("intf_q", 32'(q), 32'(e[W-1:0]));
    check("intf_sout", 32'(sout), 32'(e[W]));
    m_q = e[W-1:0]; m_sout = e[W];
    tick();

    // reset mid-shift aborts with no done pulse
    do_cmd("ld5a_b", 3'd1, 3'd0, 8'h5A, 1'b0);
    start = 1'b1; mode = 3'd2; amt = 3'd5; sin = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    res = 1'b1; tick(); res = 1'b0;
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    m_q = '0; m_sout = 1'b0;

    // start together with reset is dropped
    start = 1'b1; mode = 3'd1; din = 8'h77; res = 1'b1;
    tick(); start = 1'b0; res = 1'b0;
    check("start_res_q", 32'(q), 32'h00);
    check("start_res_done", 32'(done), 32'd0);
    tick(); check("start_res_done2", 32'(done), 32'd0);

    do_cmd("ld_c6", 3'd1, 3'd0, 8'hC6, 1'b1);
    do_cmd("shl0", 3'd2, 3'd0, 8'h00, 1'b1); check("shl0_val", 32'(q), 32'hC6);
    do_cmd("rsvd", 3'd7, 3'd5, 8'h12, 1'b1); check("rsvd_val", 32'(q), 32'hC6);

    // back-to-back: ROL accepted on the load's done cycle
    start = 1'b1; mode = 3'd1; din = 8'h01;
    tick();
    check("b2b_load_done", 32'(done), 32'd1); check("b2b_load_q", 32'(q), 32'h01);
    mode = 3'd4; amt = 3'd1;
    tick(); start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    tick();
    check("b2b_q", 32'(q), 32'h02); check("b2b_done", 32'(done), 32'd1);
    check("b2b_sout", 32'(sout), 32'd0);
    m_q = 8'h02; m_sout = 1'b0;
    tick();

    for (int i = 0; i < 60; i++) begin
      do_cmd("rnd", 3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
